// File: rtl/ram_arbiter.sv
// Arbitrates the single-port program/data RAM between the CPU core and a debug/loader master.
// Build option ARB_STARVE_EN enables the starvation counter and forced debug slot.
`timescale 1ns/1ps

module ram_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_din,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("STARVE_MAX must be within 1..15");
    end

    typedef enum logic {
        IDLE     = 1'b0,
        DBG_RESP = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              dbg_pending;
    logic              dbg_grant;
    logic              resp_we_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] rdata_q;

    // Gated by rst_n so the CPU keeps the bus (with writes off) throughout reset.
    assign dbg_pending = rst_n && dbg_req && (state == IDLE);

`ifdef ARB_STARVE_EN
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved   = (starve_cnt == CNT_MAX);
    assign dbg_grant = dbg_pending && (!cpu_req || starved);

    // Counts consecutive denied debug cycles; saturates at the forced-slot threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (dbg_grant || !dbg_req) begin
            starve_cnt <= '0;
        end else if (dbg_pending && !starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`else
    assign dbg_grant = dbg_pending && !cpu_req;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a granted access always spends exactly one cycle in DBG_RESP.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (dbg_grant) state_nxt = DBG_RESP;
            DBG_RESP: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Output logic: bus mux, stall, acknowledge and read-data shield.
    always_comb begin
        ram_addr  = cpu_addr;
        ram_din   = cpu_din;
        ram_we    = 1'b0;
        cpu_stall = 1'b0;
        dbg_ack   = 1'b0;
        cpu_dout  = ram_dout;
        dbg_rdata = rdata_q;

        if (dbg_grant) begin
            ram_addr = dbg_addr;
            ram_din  = dbg_din;
            ram_we   = dbg_we;
        end else if (rst_n) begin
            ram_we = cpu_we && cpu_req;
        end

`ifdef ARB_STARVE_EN
        cpu_stall = dbg_grant && cpu_req;
`endif

        // ram_dout comes straight off the RAM output register, so it is stable for the whole ack cycle.
        if (state == DBG_RESP) begin
            dbg_ack  = 1'b1;
            cpu_dout = hold_q;
            if (!resp_we_q) begin
                dbg_rdata = ram_dout;
            end
        end
    end

    // Grant-cycle capture of the CPU's read data, and retention of the debug read result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            rdata_q   <= '0;
            resp_we_q <= 1'b0;
        end else begin
            if (dbg_grant) begin
                hold_q    <= ram_dout;
                resp_we_q <= dbg_we;
            end
            if (state == DBG_RESP && !resp_we_q) begin
                rdata_q <= ram_dout;
            end
        end
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares the single-port 1K x 16 program/data RAM between the CPU core (control unit plus datapath muxes) and an external debug/loader master. The CPU has fixed priority. A starvation counter forces a debug slot after a bounded wait. While the debug master owns the RAM, the block stalls the CPU and shields the CPU's read data from the debug access. It sits between the core's RAM address/data muxes and the RAM macro.

Parameters:
ADDR_W, 10, RAM word-address width
DATA_W, 16, RAM word width
STARVE_MAX, 4, consecutive denied debug cycles before a forced debug slot (1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  reset
cpu_req  in  1  CPU needs the RAM this cycle
cpu_we  in  1  CPU write strobe
cpu_addr  in  ADDR_W  CPU address
cpu_din  in  DATA_W  CPU write data
cpu_dout  out  DATA_W  read data to the core
cpu_stall  out  1  core must hold state this cycle
dbg_req  in  1  debug access request, held until dbg_ack
dbg_we  in  1  debug write, qualified by dbg_req
dbg_addr  in  ADDR_W  debug address
dbg_din  in  DATA_W  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  DATA_W  registered debug read data, valid with dbg_ack
ram_addr  out  ADDR_W  to RAM
ram_din  out  DATA_W  to RAM
ram_we  out  1  to RAM
ram_dout  in  DATA_W  RAM read data, one cycle after the address (synchronous read)

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- RAM model: the address is sampled at edge N. ram_dout is valid during cycle N+1.
- States: IDLE and DBG_RESP.
- dbg_pending = dbg_req and state==IDLE.
- dbg_grant (combinational) = dbg_pending and (!cpu_req or starve_cnt==STARVE_MAX).
- Bus mux:
  - dbg_grant=1: ram_addr=dbg_addr, ram_din=dbg_din, ram_we=dbg_we, cpu_stall=cpu_req.
  - dbg_grant=0: ram_addr=cpu_addr, ram_din=cpu_din, ram_we=cpu_we and cpu_req, cpu_stall=0.
- A stalled CPU write is not performed. The core re-presents it next cycle because it holds state.
- starve_cnt:
  - Width 4 bits.
  - Increments (saturating at STARVE_MAX) each cycle dbg_pending=1 and dbg_grant=0.
  - Clears on dbg_grant, and whenever dbg_req=0.
- Transitions:
  - IDLE -> DBG_RESP on dbg_grant.
  - DBG_RESP -> IDLE unconditionally after one cycle.
- In DBG_RESP:
  - dbg_ack=1.
  - dbg_rdata is loaded from ram_dout at the end of the grant's following cycle (read), or keeps its old value (write).
  - dbg_req is ignored that cycle. The minimum debug access period is 2 cycles.
  - The CPU owns the RAM in DBG_RESP.
- Debug latency: the grant cycle plus 1. dbg_ack is asserted in the cycle after the grant. dbg_rdata is presented registered, so it is stable while dbg_ack=1.
- Read-data shield:
  - In the grant cycle, hold_q captures ram_dout, which holds the CPU's prior read.
  - In the DBG_RESP cycle, cpu_dout=hold_q. Otherwise cpu_dout=ram_dout.
  - This gives the core continuous, uncorrupted read data across the stall.
- cpu_req=0 with dbg_req=1: immediate grant, no starvation wait, no stall.
- Simultaneous starve_cnt==STARVE_MAX and CPU write: debug wins, the CPU write is deferred via cpu_stall.
- Reset values: cpu_stall=0, dbg_ack=0, dbg_rdata=0, hold_q=0, starve_cnt=0, state=IDLE.
  - While rst_n=0, ram_we=0 and ram_addr/ram_din follow the CPU.
- Reset mid-access: an in-flight debug access is dropped with no ack. A completed write may already be in RAM. The master keeps dbg_req asserted and is re-served after reset.

Optional Feature:
Macro ARB_STARVE_EN.
- Defined: starvation counter and forced debug slot as above.
- Undefined: no counter. dbg_grant = dbg_pending and !cpu_req (strict CPU priority). cpu_stall is constant 0. The hold_q shield remains because dbg_grant only occurs with cpu_req=0.

Test Plan:
1. Idle CPU (cpu_req=0), debug write 0x1234 to addr 0x055 -> ram_we=1 with ram_addr=0x055 in the grant cycle; dbg_ack pulses the next cycle; cpu_stall stays 0.
2. Idle CPU, debug read of addr 0x055 after test 1 -> dbg_ack with dbg_rdata=0x1234 one cycle after the grant.
3. cpu_req=1 continuously, dbg_req=1, STARVE_MAX=4 -> debug is denied 4 cycles, granted in the 5th with cpu_stall=1 for exactly 1 cycle, and dbg_ack in the 6th.
4. CPU reads 0x3FF (contents 0xBEEF) in the cycle before a forced debug read of 0x000 (contents 0x0F0F) -> cpu_dout=0xBEEF during the grant and DBG_RESP cycles; dbg_rdata=0x0F0F.
5. Forced slot coincides with a CPU write of 0xAAAA to 0x010 -> RAM[0x010] is unchanged during the stall; the write lands the next cycle; a readback returns 0xAAAA.
6. rst_n asserted in the grant cycle -> no dbg_ack, all outputs at reset values; dbg_req still high -> re-served after release with correct data. Rerun test 3 without ARB_STARVE_EN -> no grant while cpu_req=1.
